// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Access-size encodings, FSM state encoding, latched request bundle.
package dmem_resp_pkg;

  localparam int CPU_WIDTH             = 32;
  localparam int MEM_ACCESS_TYPE_WIDTH = 2;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic                 wen;
    logic [CPU_WIDTH-1:0] addr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [1:0]           atype;
    logic                 sext;
  } dmem_req_t;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] t
  );
    case (t)
      MEM_BYTE: return 4'b0001;
      MEM_HALF: return 4'b0011;
      MEM_WORD: return 4'b1111;
      default:  return 4'b1111;
    endcase
  endfunction

  // Reserved size 11 behaves as a word.
  function automatic logic misaligned(
    input logic [1:0] t,
    input logic [1:0] lo
  );
    return (t == MEM_HALF && lo[0]) ||
           (t[1] && lo != 2'b00);
  endfunction

  function automatic logic [1:0] align_lo(
    input logic [1:0] t,
    input logic [1:0] lo
  );
    if (t == MEM_BYTE) return lo;
    if (t == MEM_HALF) return {lo[1], 1'b0};
    return 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM: byte-enabled synchronous write, async read.
// Ports: clk, we, be[3:0], idx, wdata in; rdata out. No reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: req/resp handshake, wait states, aligned
// and extended loads, byte-enabled stores. Ports: clk, rst_n,
// req_* (valid/ready/wen/addr/wdata/access_type/sign_ext),
// resp_* (valid/ready/rdata/err). Macro DMEM_MISALIGN_CHK_EN turns
// misaligned accesses into errors instead of forcing alignment.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wen,
  input  logic [CPU_WIDTH-1:0]             req_addr,
  input  logic [CPU_WIDTH-1:0]             req_wdata,
  input  logic [MEM_ACCESS_TYPE_WIDTH-1:0] req_access_type,
  input  logic                             req_sign_ext,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [CPU_WIDTH-1:0]             resp_rdata,
  output logic                             resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e          state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  dmem_req_t            req_q, req_d;
  dmem_req_t            req_in, eff;
  logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 rdy_q;

  logic [CPU_WIDTH-1:0] addr;
  logic [CPU_WIDTH-1:0] wlane;
  logic [CPU_WIDTH-1:0] ram_rdata;
  logic [CPU_WIDTH-1:0] shifted;
  logic [CPU_WIDTH-1:0] load_data;
  logic [3:0]           be;
  logic [AW-1:0]        idx;
  logic                 err;
  logic                 go_resp;
  logic                 ram_we;
  logic                 unused_addr;

  assign req_in = '{
    wen:   req_wen,
    addr:  req_addr,
    wdata: req_wdata,
    atype: req_access_type,
    sext:  req_sign_ext
  };

  // With zero wait states the commit happens on the accept edge,
  // so decode must see the live request while idle.
  assign eff = (state_q == DMEM_IDLE) ? req_in : req_q;

  always_comb begin
    addr = eff.addr;
    err  = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    err  = misaligned(eff.atype, eff.addr[1:0]);
`else
    addr[1:0] = align_lo(eff.atype, eff.addr[1:0]);
`endif
    be    = 4'(lane_mask(eff.atype) << addr[1:0]);
    wlane = eff.wdata;
    unique case (1'b1)
      (eff.atype == MEM_BYTE): wlane = {4{eff.wdata[7:0]}};
      (eff.atype == MEM_HALF): wlane = {2{eff.wdata[15:0]}};
      default: ;
    endcase
  end

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[CPU_WIDTH-1:AW+2];

  always_comb begin
    shifted   = ram_rdata >> {addr[1:0], 3'b000};
    load_data = shifted;
    unique case (1'b1)
      (eff.atype == MEM_BYTE):
        load_data = {{24{eff.sext & shifted[7]}}, shifted[7:0]};
      (eff.atype == MEM_HALF):
        load_data = {{16{eff.sext & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (req_valid && rdy_q) begin
          req_d = req_in;
          if (WAIT_CYCLES == 0) begin
            go_resp = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) go_resp = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DMEM_RESP: begin
        if (resp_ready) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
    if (go_resp) begin
      state_d = DMEM_RESP;
      rdata_d = (eff.wen || err) ? '0 : load_data;
      err_d   = err;
    end
  end

  assign ram_we = go_resp & eff.wen & ~err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .idx  (idx),
    .wdata(wlane),
    .rdata(ram_rdata)
  );

  assign req_ready  = rdy_q && (state_q == DMEM_IDLE);
  assign resp_valid = (state_q == DMEM_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
